// File: rtl/cnt_gen.sv
// General-purpose counter: up/down, programmable terminal value, sync clear/load,
// prescaled enable, wrap/saturate/one-shot modes and registered compare match.
module cnt_gen #(
  parameter int Bits    = 8,
  parameter int PreBits = 4,
  parameter int DIV_RST = 1
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic               SCLR,
  input  logic               EN,
  input  logic               UP,
  input  logic               LD,
  input  logic [Bits-1:0]    LD_VAL,
  input  logic [1:0]         MODE,
  input  logic [Bits-1:0]    TOP,
  input  logic [Bits-1:0]    CMP,
  input  logic [PreBits-1:0] DIV,
  output logic [Bits-1:0]    Q,
  output logic               TC,
  output logic               WRAP,
  output logic               DONE,
  output logic               CMP_HIT
);

  typedef enum logic [1:0] {
    MODE_WRAP = 2'b00,
    MODE_SAT  = 2'b01,
    MODE_ONE  = 2'b10,
    MODE_ALT  = 2'b11
  } mode_e;

  if (DIV_RST < 1 || DIV_RST > (1 << PreBits)) begin : g_div_rst_chk
    $error("cnt_gen: DIV_RST outside 1..2**PreBits");
  end

  logic [Bits-1:0]    q_q, q_d;
  logic [PreBits-1:0] pre_q, pre_d;
  logic               wrap_q, wrap_d;
  logic               done_q, done_d;
  logic               cmp_hit_q, cmp_hit_d;

  logic [Bits-1:0]    term;
  logic [Bits-1:0]    q_next_step;
  logic               at_term;
  mode_e              mode;

  assign mode        = mode_e'(MODE);
  assign term        = UP ? TOP : '0;
  // An up-count already past TOP is treated as sitting on the terminal value.
  assign at_term     = UP ? (q_q >= TOP) : (q_q == '0);
  assign q_next_step = UP ? (q_q + 1'b1) : (q_q - 1'b1);

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    q_d    = q_q;
    pre_d  = pre_q;
    wrap_d = 1'b0;
    done_d = done_q;

    if (SCLR) begin
      q_d    = '0;
      pre_d  = '0;
      done_d = 1'b0;
    end else if (LD) begin
      q_d    = LD_VAL;
      pre_d  = '0;
      done_d = 1'b0;
    end else if (EN) begin
      if (pre_q < DIV) begin
        pre_d = pre_q + 1'b1;
      end else begin
        pre_d = '0;
        unique case (mode)
          MODE_SAT: begin
            if (!at_term) q_d = q_next_step;
          end
          MODE_ONE: begin
            if (!done_q && !at_term) begin
              q_d    = q_next_step;
              done_d = (q_next_step == term);
            end
          end
          MODE_WRAP, MODE_ALT: begin
            if (at_term) begin
              q_d    = UP ? '0 : TOP;
              wrap_d = 1'b1;
            end else begin
              q_d = q_next_step;
            end
          end
          default: q_d = q_q;
        endcase
      end
    end
  end

  assign cmp_hit_d = (q_d == CMP);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      q_q       <= '0;
      pre_q     <= '0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
      cmp_hit_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      pre_q     <= pre_d;
      wrap_q    <= wrap_d;
      done_q    <= done_d;
      cmp_hit_q <= cmp_hit_d;
    end
  end

  assign Q       = q_q;
  assign TC      = at_term;
  assign WRAP    = wrap_q;
  assign DONE    = done_q;
  assign CMP_HIT = cmp_hit_q;

endmodule
